// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store stage: FSM states, funct3 codes,
// store byte-enable and lane-replication functions, misalignment detection.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte enables for a store; unknown sizes still issue a request with no lanes.
    function automatic logic [3:0] store_mask(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_B:    store_mask = 4'b0001 << off;
            F3_H:    store_mask = 4'b0011 << {off[1], 1'b0};
            F3_W:    store_mask = 4'b1111;
            default: store_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] wdata);
        case (funct3)
            F3_B:    store_wdata = {4{wdata[7:0]}};
            F3_H:    store_wdata = {2{wdata[15:0]}};
            default: store_wdata = wdata;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_H, F3_HU: is_misaligned = off[0];
            F3_W:        is_misaligned = (off != 2'b00);
            default:     is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Load-lane extraction: selects the addressed byte/half of the read word and
// sign- or zero-extends it according to funct3.
module mem_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata[{off, 3'b000} +: 8];
    assign half_lane = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: default first so every path assigns data and no latch is inferred.
        data = rdata;
        case (funct3)
            F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    data = {{16{half_lane[15]}}, half_lane};
            F3_BU:   data = {24'd0, byte_lane};
            F3_HU:   data = {16'd0, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_phase.sv
// Load/store stage: IDLE/REQ/WAIT handshake with data memory, timeout, and
// registered writeback result. Optional MEM_MISALIGN_TRAP_EN adds misalignment traps.
module mem_phase
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd_waddr,
    input  logic        i_reg_write,
    output logic        o_valid,
    output logic [4:0]  o_rd_waddr,
    output logic        o_reg_write,
    output logic [31:0] o_rd_wdata,
    output logic        o_dmem_req,
    output logic        o_dmem_wen,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        o_misaligned,
`endif
    output logic        o_err
);

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [1:0]  lat_off;
    logic [2:0]  lat_funct3;
    logic [4:0]  lat_rd;
    logic        lat_reg_write;
    logic        lat_store;
    logic        accept;
    logic        is_mem;
    logic [31:0] load_data;

    assign o_ready = (state == IDLE);
    assign accept  = i_valid & o_ready;
    assign is_mem  = i_mem_read | i_mem_write;

    mem_align u_align (
        .rdata  (i_dmem_rdata),
        .off    (lat_off),
        .funct3 (lat_funct3),
        .data   (load_data)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            lat_off       <= 2'd0;
            lat_funct3    <= 3'd0;
            lat_rd        <= 5'd0;
            lat_reg_write <= 1'b0;
            lat_store     <= 1'b0;
            o_valid       <= 1'b0;
            o_rd_waddr    <= 5'd0;
            o_reg_write   <= 1'b0;
            o_rd_wdata    <= 32'd0;
            o_dmem_req    <= 1'b0;
            o_dmem_wen    <= 1'b0;
            o_dmem_addr   <= 32'd0;
            o_dmem_wdata  <= 32'd0;
            o_dmem_mask   <= 4'd0;
            o_err         <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            o_misaligned  <= 1'b0;
`endif
        end else begin
            o_valid     <= 1'b0;
            o_reg_write <= 1'b0;
            o_err       <= 1'b0;
            o_dmem_req  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            o_misaligned <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_off       <= i_addr[1:0];
                        lat_funct3    <= i_funct3;
                        lat_rd        <= i_rd_waddr;
                        lat_reg_write <= i_reg_write;
                        lat_store     <= i_mem_write;
                        if (!is_mem) begin
                            o_valid     <= 1'b1;
                            o_rd_waddr  <= i_rd_waddr;
                            o_reg_write <= i_reg_write;
                            o_rd_wdata  <= i_addr;
                        end
`ifdef MEM_MISALIGN_TRAP_EN
                        else if (is_misaligned(i_funct3, i_addr[1:0])) begin
                            o_valid      <= 1'b1;
                            o_misaligned <= 1'b1;
                            o_rd_waddr   <= i_rd_waddr;
                            o_rd_wdata   <= i_addr;
                        end
`endif
                        else begin
                            state        <= REQ;
                            o_dmem_req   <= 1'b1;
                            o_dmem_wen   <= i_mem_write;
                            o_dmem_addr  <= {i_addr[31:2], 2'b00};
                            o_dmem_wdata <= store_wdata(i_funct3, i_wdata);
                            o_dmem_mask  <= store_mask(i_funct3, i_addr[1:0]);
                        end
                    end
                end
                REQ: begin
                    state    <= WAIT;
                    wait_cnt <= 8'd0;
                end
                WAIT: begin
                    if (i_dmem_rvalid) begin
                        state      <= IDLE;
                        o_valid    <= 1'b1;
                        o_rd_waddr <= lat_rd;
                        if (lat_store) begin
                            o_rd_wdata <= 32'd0;
                        end else begin
                            o_rd_wdata  <= load_data;
                            o_reg_write <= lat_reg_write;
                        end
                    end else if (wait_cnt == MAX_W - 8'd1) begin
                        // Final empty WAIT cycle brings the count to MAX_WAIT.
                        state      <= IDLE;
                        wait_cnt   <= wait_cnt + 8'd1;
                        o_valid    <= 1'b1;
                        o_err      <= 1'b1;
                        o_rd_waddr <= lat_rd;
                        o_rd_wdata <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
